// File: rtl/adder_pkg.sv
// Shared types and widths for the adder built-in self-test.
package adder_pkg;

    localparam int IDX_W = 6;
    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Vector count for a given adder width; must stay <= 2**IDX_W.
    function automatic int num_vectors(input int width);
        return 3 * width + 3;
    endfunction

endpackage

// File: rtl/adder_bist_vecgen.sv
// Combinational map from vector index to the operands and carry-in applied to the adder.
module adder_bist_vecgen
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o
);

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        a_o   = '0;
        b_o   = '0;
        cin_o = 1'b0;
        if (idx_i == IDX_W'(1)) begin
            cin_o = 1'b1;
        end else if (idx_i == IDX_W'(3 * WIDTH + 2)) begin
            a_o   = '1;
            cin_o = 1'b1;
        end else begin
            // Walking-one per bit: A alone, B alone, then both to exercise the carry out of bit i.
            for (int i = 0; i < WIDTH; i++) begin
                if (idx_i == IDX_W'(2 + 3 * i)) a_o[i] = 1'b1;
                if (idx_i == IDX_W'(3 + 3 * i)) b_o[i] = 1'b1;
                if (idx_i == IDX_W'(4 + 3 * i)) begin
                    a_o[i] = 1'b1;
                    b_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_bist.sv
// Self-test controller: drives a fixed vector table into an external adder and
// counts vectors whose {cout, s} differs from a + b + cin.
module adder_bist
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail
);

    localparam int               N        = num_vectors(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam int               WAIT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               cin_q;
    logic               busy_q, done_q, pass_q;
    logic [ERR_W-1:0]   err_q;
    logic [IDX_W-1:0]   first_fail_q;

    logic [WIDTH-1:0]   vec_a_d, vec_b_d;
    logic               vec_cin_d;
    logic [WIDTH:0]     expected_d;
    logic               mismatch_d;

    adder_bist_vecgen #(.WIDTH(WIDTH)) u_vecgen (
        .idx_i (idx_q),
        .a_o   (vec_a_d),
        .b_o   (vec_b_d),
        .cin_o (vec_cin_d)
    );

    always_comb begin
        expected_d = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        mismatch_d = ({cout, s} != expected_d);
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_APPLY;
                        idx_q        <= '0;
                        err_q        <= '0;
                        first_fail_q <= '0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    a_q     <= vec_a_d;
                    b_q     <= vec_b_d;
                    cin_q   <= vec_cin_d;
                    wait_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_W'(SETTLE - 1)) state_q <= ST_CHECK;
                    else                               wait_q  <= wait_q + 1'b1;
                end
                ST_CHECK: begin
                    // err_q is still zero only until the first mismatch of this run.
                    if (mismatch_d) begin
                        if (err_q != '1) err_q        <= err_q + 1'b1;
                        if (err_q == '0) first_fail_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch_d;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_APPLY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign cin        = cin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench for adder_bist: a fault-injectable adder model, a reference
// vector table, and a monitor that checks applied vectors and run results.
module tb_adder_bist;

    localparam int W      = 16;
    localparam int SETTLE = 2;
    localparam int P      = SETTLE + 2;
    localparam int N      = 3 * W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b, s;
    logic         cin, cout;
    logic         busy, done, pass;
    logic [7:0]   err_count;
    logic [5:0]   first_fail;

    int mode = 0;
    int cyc  = 0;
    int checks = 0;
    int failures = 0;
    bit overlap_seen = 1'b0;

    typedef struct {
        int acc;
        int errs;
        int ff;
        bit pass;
    } run_t;

    run_t exp_q[$];

    adder_bist #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .s          (s),
        .cout       (cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test: 0 ideal, 1 s[5] stuck at 0, 2 cout stuck at 0, 3 off by +1.
    function automatic logic [W:0] model_resp(input int md, input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        case (md)
            1:       r[5] = 1'b0;
            2:       r[W] = 1'b0;
            3:       r    = r + 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout, s} = model_resp(mode, a, b, cin);

    function automatic void vec_of(input int k, output logic [W-1:0] va, output logic [W-1:0] vb,
                                   output logic vc);
        int j;
        va = '0;
        vb = '0;
        vc = 1'b0;
        if (k == 1) begin
            vc = 1'b1;
        end else if (k == N - 1) begin
            va = '1;
            vc = 1'b1;
        end else if (k >= 2) begin
            j = k - 2;
            if (j % 3 != 1) va = W'(1) << (j / 3);
            if (j % 3 != 0) vb = W'(1) << (j / 3);
        end
    endfunction

    // Expected run outcome from plain integer arithmetic over the whole table.
    function automatic run_t ref_run(input int md, input int acc);
        run_t r;
        logic [W-1:0] va, vb;
        logic vc;
        int ideal, got;
        r.acc  = acc;
        r.errs = 0;
        r.ff   = 0;
        for (int k = 0; k < N; k++) begin
            vec_of(k, va, vb, vc);
            ideal = int'(va) + int'(vb) + int'(vc);
            got   = int'(model_resp(md, va, vb, vc));
            if (got != ideal) begin
                if (r.errs == 0) r.ff = k;
                if (r.errs < 255) r.errs++;
            end
        end
        r.pass = (r.errs == 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < P * N + 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Pulse start for one cycle; returns the cycle number of the accepting edge.
    task automatic pulse_start(output int acc);
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_mode(input int md, input string name);
        int acc;
        mode = md;
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        exp_q.push_back(ref_run(md, acc));
        @(negedge clk);
        start = 1'b0;
        wait_done(name);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_cin"}, cin, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_ff"}, first_fail, 0);
    endtask

    // Monitor: checks each applied vector and the result whenever done rises.
    initial begin : monitor
        run_t cur;
        bit active = 1'b0;
        bit done_prev = 1'b0;
        int rel;
        logic [W-1:0] va, vb;
        logic vc;
        forever begin
            @(negedge clk);
            if (busy && done) overlap_seen = 1'b1;
            if (rst) begin
                active    = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (!active && exp_q.size() > 0 && cyc >= exp_q[0].acc) begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                end
                if (active) begin
                    rel = cyc - cur.acc;
                    if (rel % P == 1 && rel / P < N) begin
                        vec_of(rel / P, va, vb, vc);
                        check("vec_a", a, va);
                        check("vec_b", b, vb);
                        check("vec_cin", cin, vc);
                    end
                end
                if (done && !done_prev) begin
                    if (!active) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        vec_of(N - 1, va, vb, vc);
                        check("done_latency", cyc - cur.acc, P * N);
                        check("err_count", err_count, cur.errs);
                        check("first_fail", first_fail, cur.ff);
                        check("pass", pass, cur.pass);
                        check("hold_a", a, va);
                        check("hold_b", b, vb);
                        check("hold_cin", cin, vc);
                        active = 1'b0;
                    end
                end
                done_prev = done;
            end
        end
    end

    initial begin : stimulus
        int acc;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        rst   = 1'b0;

        run_mode(0, "ideal");
        run_mode(1, "s5_stuck");
        run_mode(2, "cout_stuck");
        run_mode(3, "plus_one");

        // Reset while vector 20 is in flight, then a clean run.
        mode = 0;
        pulse_start(acc);
        wait_cyc(acc + 20 * P + 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_rst");
        rst = 1'b0;
        run_mode(0, "after_rst");

        // start held through a whole run: ignored while busy, restarts from DONE.
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        exp_q.push_back(ref_run(3, acc));
        exp_q.push_back(ref_run(0, acc + P * N + 1));
        wait_done("held_first");
        mode = 0;
        @(negedge clk);
        check("restart_busy", busy, 1);
        check("restart_err_cleared", err_count, 0);
        check("restart_done_low", done, 0);
        start = 1'b0;
        wait_done("held_second");
        @(negedge clk);

        // Saturation: preload 254 before the last two (failing) vectors.
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        exp_q.push_back('{acc: acc, errs: 255, ff: 0, pass: 1'b0});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(acc + 49 * P + 2);
        force dut.err_q = 8'd254;
        #1;
        release dut.err_q;
        wait_cyc(acc + 50 * P);
        check("sat_reach", err_count, 255);
        wait_done("saturate");
        @(negedge clk);

        check("busy_done_exclusive", overlap_seen, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter WIDTH, default 16: data width of the adder under test; WIDTH >= 2.
REQ-002 Parameter SETTLE, default 2: cycles allowed for the DUT sum to settle per vector; SETTLE >= 1.
REQ-003 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port start  input  1: request a test run; sampled only in IDLE and DONE.
REQ-006 Port a  output  WIDTH: operand A driven to the DUT, registered.
REQ-007 Port b  output  WIDTH: operand B driven to the DUT, registered.
REQ-008 Port cin  output  1: carry-in driven to the DUT, registered.
REQ-009 Port s  input  WIDTH: DUT sum.
REQ-010 Port cout  input  1: DUT carry-out.
REQ-011 Port busy  output  1: high while a run is in progress.
REQ-012 Port done  output  1: high from run completion until the next accepted start or reset.
REQ-013 Port pass  output  1: high with done when err_count == 0.
REQ-014 Port err_count  output  8: mismatching vectors in the last run, saturating at 255.
REQ-015 Port first_fail  output  6: index of the first mismatching vector; 0 when no mismatch.

Function
REQ-016 Vector table, N = 3*WIDTH+3 entries (51 at WIDTH=16), applied in index order:
- idx 0: a=0, b=0, cin=0
- idx 1: a=0, b=0, cin=1
- for i in 0..WIDTH-1: idx 2+3i: a=1<<i, b=0, cin=0; idx 3+3i: a=0, b=1<<i, cin=0; idx 4+3i: a=b=1<<i, cin=0
- idx N-1: a=all ones, b=0, cin=1 (full carry ripple)
REQ-017 Expected result is the (WIDTH+1)-bit value a+b+cin; {cout,s} is compared against it, both fields exactly.
REQ-018 FSM states IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE --start--> APPLY; this edge clears err_count, first_fail, done, pass and the vector index.
- APPLY: load a/b/cin for the current index -> WAIT.
- WAIT: stay exactly SETTLE cycles -> CHECK.
- CHECK: compare; if index == N-1 -> DONE, else increment index -> APPLY.
REQ-019 Each vector takes SETTLE+2 cycles; done rises (SETTLE+2)*N edges after the edge that accepts start (204 at defaults).
REQ-020 On a mismatch in CHECK, err_count increments, saturating at 255; first_fail records the index only on the first mismatch of the run.
REQ-021 busy is high in APPLY, WAIT and CHECK; done and busy are never high together.
REQ-022 start is ignored while busy; start held high in DONE begins a new run.
REQ-023 a, b and cin hold the last applied vector in DONE and are 0 in IDLE.
REQ-024 Index width is 6 bits; N must be <= 64, so WIDTH <= 20.

Reset
REQ-025 rst high at a rising edge forces IDLE and sets a, b, cin, busy, done, pass, err_count and first_fail to 0, including mid-run; rst has priority over start.

Structure
REQ-026 A shared package adder_pkg holds the FSM state enum, the index width constant (6) and the err_count width constant (8).
REQ-027 Vector generation (index -> a, b, cin) is a combinational sub-module adder_bist_vecgen, instantiated once.

Verification
REQ-028 Ideal WIDTH=16 adder model, start pulsed for one cycle -> done high 204 edges later, pass=1, err_count=0, first_fail=0.
REQ-029 Model with s[5] stuck at 0 -> err_count=3 (idx 16, 17, 18), first_fail=16, pass=0.
REQ-030 Model with cout stuck at 0 -> err_count=2 (idx 49, 50), first_fail=49.
REQ-031 rst asserted at vector index 20 -> next cycle IDLE with all outputs 0; a new start gives a full 204-edge run.
REQ-032 start held high for a whole run -> start ignored while busy; a second run begins the cycle after DONE is entered; err_count is cleared on the restart.
REQ-033 Model returning s = a+b+cin+1 -> every vector fails, err_count=51, first_fail=0; check that err_count stays at 255 rather than wrapping, using a forced counter preload of 254 and two further mismatches.
